sram_access_sequencer: RTL

- Single-port read/write sequencer for the 6T SRAM macro array (ROWS words x WORD bits).
- Converts a valid/ready request into the array's precharge, bitline-drive, wordline, write_en and sense_en control sequence.
- Returns read data captured from the sense amplifiers, or a write acknowledge.
- Sits between the DPE-side memory client and the array; it is the only driver of the array's global write_en and sense_en.

---
 rtl/sram_access_sequencer_if.sv | 22 ++
 rtl/sram_access_sequencer.sv | 93 +++++++++
 2 files changed

// File: rtl/sram_access_sequencer_if.sv
// sram_access_sequencer_if: request/response bus between the memory client and the SRAM sequencer
interface sram_access_sequencer_if #(
  parameter int WORD = 32,
  parameter int ADDR_W = 5
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_err;
  logic [WORD-1:0] rsp_rdata;
  modport master(
    output req_valid, req_we, req_addr, req_wdata,
    input req_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave(
    input req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer: turns one request at a time into precharge/drive/wordline/sense control for a 6T SRAM array
module sram_access_sequencer #(
  parameter int ROWS = 32,
  parameter int WORD = 32,
  parameter int ADDR_W = 5,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC = 2,
  parameter int SENSE_CYC = 1
) (
  input logic clk,
  input logic rst,
  sram_access_sequencer_if.slave bus,
  output logic precharge_en,
  output logic bl_drive_en,
  output logic [WORD-1:0] bl_wdata,
  output logic [ROWS-1:0] wl_sel,
  output logic write_en,
  output logic sense_en,
  input logic [WORD-1:0] sa_dout,
  output logic busy
);
  localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? ((PRE_CYC > SENSE_CYC) ? PRE_CYC : SENSE_CYC)
                                              : ((WL_CYC > SENSE_CYC) ? WL_CYC : SENSE_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [ADDR_W:0] ROWS_W = (ADDR_W + 1)'(ROWS);
  typedef enum logic [2:0] {IDLE, PRE, DRIVE, ACCESS, SENSE, HOLD, RECOV} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic we_q, err_q, err_in;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD-1:0] wdata_q, rdata_q;
  logic wl_on;
  assign err_in = {1'b0, bus.req_addr} >= ROWS_W;
  // state, phase counter, latched request and captured read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && bus.req_valid) begin
        we_q <= bus.req_we;
        err_q <= err_in;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == SENSE && cnt == '0) rdata_q <= sa_dout;
    end
  end
  // next state; the counter is loaded with (length-1) on entry to each timed phase
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = err_in ? RECOV : PRE;
        cnt_n = CW'(PRE_CYC - 1);
      end
      PRE: if (cnt == '0) begin
        state_n = we_q ? DRIVE : ACCESS;
        cnt_n = CW'(WL_CYC - 1);
      end else cnt_n = cnt - 1'b1;
      DRIVE: state_n = ACCESS;
      ACCESS: if (cnt == '0) begin
        state_n = we_q ? HOLD : SENSE;
        cnt_n = CW'(SENSE_CYC - 1);
      end else cnt_n = cnt - 1'b1;
      SENSE: if (cnt == '0) state_n = RECOV;
             else cnt_n = cnt - 1'b1;
      HOLD: state_n = RECOV;
      RECOV: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign wl_on = state == ACCESS || state == SENSE;
  assign precharge_en = state == PRE;
  assign write_en = state == ACCESS && we_q;
  assign bl_drive_en = state == DRIVE || state == HOLD || write_en;
  assign bl_wdata = bl_drive_en ? wdata_q : '0;
  assign sense_en = state == SENSE;
  assign wl_sel = wl_on ? ROWS'(1) << addr_q : '0;
  assign busy = state != IDLE;
  assign bus.req_ready = state == IDLE && !rst;
  assign bus.rsp_valid = state == RECOV;
  assign bus.rsp_err = state == RECOV && err_q;
  assign bus.rsp_rdata = rdata_q;
endmodule
